// File: rtl/i2c_pkg.sv
// Shared definitions for the write-only I2C master: FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ADDR     = 3'd2,
    S_ADDR_ACK = 3'd3,
    S_LOAD     = 3'd4,
    S_DATA     = 3'd5,
    S_DATA_ACK = 3'd6,
    S_STOP     = 3'd7
  } state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic ACK       = 1'b0;

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter/phase timebase for one SCL bit: CLK_DIV clocks per quarter, four quarters per bit.
module i2c_scl_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] phase,
  output logic       q_end,
  output logic       scl_hi
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  logic [QW-1:0] q_q, q_d;
  logic [1:0]    p_q, p_d;

  assign q_end  = en && (q_q == Q_LAST);
  assign phase  = p_q;
  assign scl_hi = p_q[1];

  // Disabled or cleared means "parked at the start of p0", so a resumed bit is always full length.
  always_comb begin
    q_d = q_q;
    p_d = p_q;
    if (!en || clr) begin
      q_d = '0;
      p_d = '0;
    end else if (q_end) begin
      q_d = '0;
      p_d = p_q + 2'd1;
    end else begin
      q_d = q_q + QW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
      p_q <= '0;
    end else begin
      q_q <= q_d;
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, streamed data bytes with ACK checks, STOP.
// Bus outputs are registered from current state/phase, so they trail the timebase by one CLK uniformly.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_start,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       SCL,
  output logic       SDA_oe,
  input  logic       SDA_in,
  output logic       bit_count,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [2:0] dbg_state
);

  state_e      state_q;
  logic        scl_q, sda_oe_q, bit_count_q, busy_q, done_q, ack_err_q;
  logic        last_q, nack_q;
  logic [7:0]  sh_q;
  logic [2:0]  cnt_q;

  logic [1:0]  phase;
  logic        q_end, scl_hi, bit_end, gen_en, gen_clr;

  assign gen_en  = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign gen_clr = (state_q == S_START) && q_end && (phase == 2'd1);
  assign bit_end = q_end && (phase == 2'd3);

  i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
    .CLK    (CLK),
    .RST    (RST),
    .en     (gen_en),
    .clr    (gen_clr),
    .phase  (phase),
    .q_end  (q_end),
    .scl_hi (scl_hi)
  );

  // Byte handshake: a byte transfers on a CLK edge where tx_valid && tx_ready; ready only exists in LOAD.
  assign tx_ready  = (state_q == S_LOAD) && tx_valid;
  assign SCL       = scl_q;
  assign SDA_oe    = sda_oe_q;
  assign bit_count = bit_count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign dbg_state = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      bit_count_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      last_q      <= 1'b0;
      nack_q      <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      bit_count_q <= ((state_q == S_ADDR) || (state_q == S_DATA)) && scl_hi;
      case (state_q)
        S_IDLE: begin
          scl_q    <= 1'b1;
          sda_oe_q <= 1'b0;
          // The done cycle is IDLE entry; a new command is taken only from the following CLK.
          if (cmd_start && !done_q) begin
            state_q   <= S_START;
            busy_q    <= 1'b1;
            ack_err_q <= 1'b0;
            sh_q      <= {cmd_addr, I2C_WRITE};
            cnt_q     <= '0;
          end
        end
        S_START: begin
          scl_q    <= 1'b1;
          sda_oe_q <= 1'b1;
          if (gen_clr) state_q <= S_ADDR;
        end
        S_ADDR, S_DATA: begin
          scl_q <= scl_hi;
          if (phase != 2'd0) sda_oe_q <= ~sh_q[7];
          if (bit_end) begin
            sh_q  <= {sh_q[6:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          scl_q <= scl_hi;
          if (phase != 2'd0) sda_oe_q <= 1'b0;
          if (q_end && (phase == 2'd2)) nack_q <= SDA_in;
          if (bit_end) begin
            if (nack_q != ACK) begin
              ack_err_q <= 1'b1;
              state_q   <= S_STOP;
            end else if ((state_q == S_ADDR_ACK) || !last_q) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_STOP;
            end
          end
        end
        S_LOAD: begin
          scl_q <= 1'b0;
          if (tx_valid) begin
            sh_q    <= tx_data;
            last_q  <= tx_last;
            state_q <= S_DATA;
          end
        end
        S_STOP: begin
          scl_q <= scl_hi;
          // SDA goes low only once SCL is already low, and is released in p3 while SCL is high.
          if ((phase == 2'd1) || (phase == 2'd2)) sda_oe_q <= 1'b1;
          else if (phase == 2'd3)                sda_oe_q <= 1'b0;
          if (bit_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Scoreboarded bench for i2c_master_tx: a slave/receiver model decodes the bus into events
// (START, byte, STOP, byte handshake, done) that are checked in order against an expected queue.
module tb_i2c_master_tx;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int W       = 11;
  localparam logic [2:0] T_START = 3'd0;
  localparam logic [2:0] T_BYTE  = 3'd1;
  localparam logic [2:0] T_STOP  = 3'd2;
  localparam logic [2:0] T_DONE  = 3'd3;
  localparam logic [2:0] T_TXRDY = 3'd4;

  logic       CLK       = 1'b0;
  logic       RST       = 1'b1;
  logic       cmd_start = 1'b0;
  logic [6:0] cmd_addr  = '0;
  logic [7:0] tx_data   = '0;
  logic       tx_valid  = 1'b0;
  logic       tx_last   = 1'b0;
  logic       tx_ready, SCL, SDA_oe, SDA_in, bit_count, busy, done, ack_err;
  logic [2:0] dbg_state;
  logic       slave_pull = 1'b0;

  assign SDA_in = ~(SDA_oe | slave_pull);

  i2c_master_tx #(.CLK_DIV(CLK_DIV)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_start (cmd_start),
    .cmd_addr  (cmd_addr),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .SCL       (SCL),
    .SDA_oe    (SDA_oe),
    .SDA_in    (SDA_in),
    .bit_count (bit_count),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input logic [2:0] tag, input logic [7:0] val);
    exp_q.push_back({tag, val});
  endtask

  task automatic observe(input logic [W-1:0] ev);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got %0h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      check("bus_event", 32'(ev), 32'(e));
    end
  endtask

  // ---------------- monitor / slave receiver model ----------------
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_bc = 1'b0;
  logic       in_high = 1'b0, bc_at_rise = 1'b0;
  logic [7:0] rx = '0;
  int         bitn = 0, byte_idx = 0, nack_idx = -1;
  int         last_rise = 0, last_fall = 0, max_low = 0, bc_rises = 0;

  always @(negedge CLK) begin
    logic sda;
    sda = SDA_in;
    if (RST) begin
      bitn       = 0;
      byte_idx   = 0;
      in_high    = 1'b0;
      slave_pull = 1'b0;
    end else begin
      if (prev_scl && SCL && prev_sda && !sda) begin
        observe({T_START, 8'h00});
        bitn     = 0;
        byte_idx = 0;
        in_high  = 1'b0;
      end else if (prev_scl && SCL && !prev_sda && sda) begin
        observe({T_STOP, 8'h00});
        bitn = 0;
      end
      if (!prev_scl && SCL) begin
        if (bitn != 0) check("scl_period", 32'(cyc - last_rise), 32'(4 * CLK_DIV));
        if (cyc - last_fall > max_low) max_low = cyc - last_fall;
        last_rise  = cyc;
        in_high    = 1'b1;
        bc_at_rise = bit_count;
      end
      if (prev_scl && !SCL) begin
        last_fall = cyc;
        if (in_high) begin
          if (bitn < 8) begin
            check("bit_count_data", 32'(bc_at_rise), 32'(1));
            rx   = {rx[6:0], prev_sda};
            bitn = bitn + 1;
            if (bitn == 8) observe({T_BYTE, rx});
          end else begin
            check("bit_count_ack", 32'(bc_at_rise), 32'(0));
            bitn     = 0;
            byte_idx = byte_idx + 1;
          end
        end
        in_high    = 1'b0;
        slave_pull = (bitn == 8) && (byte_idx != nack_idx);
      end
      if (bit_count && !prev_bc) bc_rises++;
      if (tx_ready) observe({T_TXRDY, tx_data});
      if (done)     observe({T_DONE, 7'h00, ack_err});
    end
    prev_scl = SCL;
    prev_sda = sda;
    prev_bc  = bit_count;
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [6:0] a);
    @(posedge CLK); #1;
    cmd_start = 1'b1;
    cmd_addr  = a;
    @(posedge CLK); #1;
    cmd_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input logic last, output logic taken);
    logic ended;
    taken    = 1'b0;
    ended    = 1'b0;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (tx_ready) begin taken = 1'b1; ended = 1'b1; break; end
      if (!busy)    begin ended = 1'b1; break; end
    end
    if (!ended) begin
      vectors++; miscompares++;
      $display("FAIL feed_timeout: got no handshake expected handshake or idle");
    end
    @(posedge CLK); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done pulse");
    end
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (!busy) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic wait_load();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (dbg_state == S_LOAD) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL load_timeout: got no LOAD expected LOAD");
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic taken;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_scl",       32'(SCL),       32'(1));
    check("rst_sda_oe",    32'(SDA_oe),    32'(0));
    check("rst_bit_count", 32'(bit_count), 32'(0));
    check("rst_tx_ready",  32'(tx_ready),  32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_done",      32'(done),      32'(0));
    check("rst_ack_err",   32'(ack_err),   32'(0));
    check("rst_state",     32'(dbg_state), 32'(S_IDLE));
    RST = 1'b0;

    // 1: addr 0x50, one byte 0xA5, slave ACKs; cmd_start on the done cycle is ignored
    nack_idx = -1;
    bc_rises = 0;
    expect_ev(T_START, 8'h00);
    expect_ev(T_BYTE,  8'hA0);
    expect_ev(T_TXRDY, 8'hA5);
    expect_ev(T_BYTE,  8'hA5);
    expect_ev(T_STOP,  8'h00);
    expect_ev(T_DONE,  8'h00);
    start_cmd(7'h50);
    feed(8'hA5, 1'b1, taken);
    check("t1_taken", 32'(taken), 32'(1));
    wait_done();
    cmd_start = 1'b1;
    cmd_addr  = 7'h33;
    @(posedge CLK); #1;
    cmd_start = 1'b0;
    check("t1_start_on_done_ignored", 32'(busy), 32'(0));
    check("t1_ack_err", 32'(ack_err), 32'(0));
    check("t1_bit_count_highs", 32'(bc_rises), 32'(16));

    // 2: address NACK -> STOP, no byte consumed, ack_err sticky
    nack_idx = 0;
    expect_ev(T_START, 8'h00);
    expect_ev(T_BYTE,  8'h54);
    expect_ev(T_STOP,  8'h00);
    expect_ev(T_DONE,  8'h01);
    start_cmd(7'h2A);
    feed(8'h11, 1'b1, taken);
    check("t2_not_taken", 32'(taken), 32'(0));
    wait_idle();
    check("t2_ack_err", 32'(ack_err), 32'(1));
    repeat (5) @(posedge CLK);
    #1;
    check("t2_ack_err_sticky", 32'(ack_err), 32'(1));

    // 3: three bytes with a 40-CLK gap before byte 2 -> SCL held low
    nack_idx = -1;
    max_low  = 0;
    expect_ev(T_START, 8'h00);
    expect_ev(T_BYTE,  8'h22);
    expect_ev(T_TXRDY, 8'h01);
    expect_ev(T_BYTE,  8'h01);
    expect_ev(T_TXRDY, 8'h80);
    expect_ev(T_BYTE,  8'h80);
    expect_ev(T_TXRDY, 8'hFF);
    expect_ev(T_BYTE,  8'hFF);
    expect_ev(T_STOP,  8'h00);
    expect_ev(T_DONE,  8'h00);
    start_cmd(7'h11);
    check("t3_ack_err_cleared", 32'(ack_err), 32'(0));
    feed(8'h01, 1'b0, taken);
    check("t3_taken0", 32'(taken), 32'(1));
    wait_load();
    repeat (40) @(posedge CLK);
    #1;
    feed(8'h80, 1'b0, taken);
    check("t3_taken1", 32'(taken), 32'(1));
    feed(8'hFF, 1'b1, taken);
    check("t3_taken2", 32'(taken), 32'(1));
    wait_idle();
    check("t3_scl_stall_ge40", 32'(max_low >= 40), 32'(1));

    // 4: data NACK on byte 1 of 2 -> STOP, byte 2 not consumed
    nack_idx = 1;
    expect_ev(T_START, 8'h00);
    expect_ev(T_BYTE,  8'h90);
    expect_ev(T_TXRDY, 8'h3C);
    expect_ev(T_BYTE,  8'h3C);
    expect_ev(T_STOP,  8'h00);
    expect_ev(T_DONE,  8'h01);
    start_cmd(7'h48);
    feed(8'h3C, 1'b0, taken);
    check("t4_taken0", 32'(taken), 32'(1));
    feed(8'hC3, 1'b1, taken);
    check("t4_byte2_not_taken", 32'(taken), 32'(0));
    wait_idle();
    check("t4_ack_err", 32'(ack_err), 32'(1));

    // 5: cmd_start mid-transfer ignored; RST mid-DATA releases the bus next CLK
    nack_idx = -1;
    expect_ev(T_START, 8'h00);
    expect_ev(T_BYTE,  8'hFE);
    expect_ev(T_TXRDY, 8'h5A);
    start_cmd(7'h7F);
    repeat (20) @(posedge CLK);
    #1;
    cmd_start = 1'b1;
    cmd_addr  = 7'h01;
    @(posedge CLK); #1;
    cmd_start = 1'b0;
    feed(8'h5A, 1'b0, taken);
    check("t5_taken", 32'(taken), 32'(1));
    repeat (50) @(posedge CLK);
    #1;
    check("t5_in_data", 32'(dbg_state), 32'(S_DATA));
    RST = 1'b1;
    @(posedge CLK); #1;
    check("t5_rst_scl",    32'(SCL),       32'(1));
    check("t5_rst_sda_oe", 32'(SDA_oe),    32'(0));
    check("t5_rst_busy",   32'(busy),      32'(0));
    check("t5_rst_bitcnt", 32'(bit_count), 32'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    check("t5_queue_drained", 32'(exp_q.size()), 32'(0));

    // 6: clean 1-byte write after reset; START/STOP framing and 16 bit_count highs
    nack_idx = -1;
    bc_rises = 0;
    expect_ev(T_START, 8'h00);
    expect_ev(T_BYTE,  8'h1E);
    expect_ev(T_TXRDY, 8'h00);
    expect_ev(T_BYTE,  8'h00);
    expect_ev(T_STOP,  8'h00);
    expect_ev(T_DONE,  8'h00);
    start_cmd(7'h0F);
    feed(8'h00, 1'b1, taken);
    check("t6_taken", 32'(taken), 32'(1));
    wait_idle();
    check("t6_bit_count_highs", 32'(bc_rises), 32'(16));

    repeat (4) @(posedge CLK);
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
